// File: rtl/muldiv_control.sv
// muldiv_control: sequencer for the signed multiply/divide unit behind HI/LO.
// Booth radix-2 multiply (33 cycles) or restoring divide (34 cycles).
// Ports: clk, rst_n (async, active-low); start/op_div/src_a/src_b request;
// busy, done, divby0 status; hi/lo result registers.
// Build option: MULDIV_EARLY_ZERO_EN finishes zero-operand ops in 1 cycle.
module muldiv_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] acc;    // Booth accumulator / divide remainder
    logic [WIDTH-1:0] mq;   // multiplier / quotient
    logic [WIDTH-1:0] opb;  // multiplicand / |divisor|
    logic           qm1;
    logic           sa;     // dividend sign
    logic           sq;     // quotient sign
    logic           dz;

    logic           last;
    logic           dz0;
    logic           ez;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign last = (cnt == CW'(WIDTH - 1));
    assign dz0  = op_div && (src_b == '0);
    assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;

`ifdef MULDIV_EARLY_ZERO_EN
    assign ez = op_div ? (src_a == '0)
                       : (src_a == '0) || (src_b == '0);
`else
    assign ez = 1'b0;
`endif

    // Booth step: one extra accumulator bit keeps acc - (-2^(W-1)) exact.
    logic [WIDTH:0]   mcand_x, booth_sum, booth_acc;
    logic [WIDTH-1:0] booth_mq;

    assign mcand_x = {opb[WIDTH-1], opb};

    always_comb begin
        case ({mq[0], qm1})
            2'b01:   booth_sum = acc + mcand_x;
            2'b10:   booth_sum = acc - mcand_x;
            default: booth_sum = acc;
        endcase
    end

    assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_mq  = {booth_sum[0], mq[WIDTH-1:1]};

    // Restoring step: borrow out of the W+1 bit trial means restore.
    logic [WIDTH:0]   div_sh, div_tr;
    logic [WIDTH-1:0] div_rem, div_q;

    assign div_sh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, opb};
    assign div_rem = div_tr[WIDTH] ? div_sh[WIDTH-1:0]
                                   : div_tr[WIDTH-1:0];
    assign div_q   = {mq[WIDTH-2:0], ~div_tr[WIDTH]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (dz0 || ez) state_nx = S_DONE;
                    else if (op_div) state_nx = S_DIV;
                    else state_nx = S_MULT;
                end
            end
            S_MULT:  if (last) state_nx = S_DONE;
            S_DIV:   if (last) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs and result write-back
    logic             res_we;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        divby0 = (state == S_DONE) && dz;
        res_we = 1'b0;
        res_hi = '0;
        res_lo = '0;
        unique case (state)
            S_IDLE: res_we = start && !dz0 && ez;
            S_MULT: begin
                res_we = last;
                res_hi = booth_acc[WIDTH-1:0];
                res_lo = booth_mq;
            end
            S_FIX: begin
                res_we = 1'b1;
                res_hi = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_lo = sq ? -mq : mq;
            end
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            mq  <= '0;
            opb <= '0;
            qm1 <= 1'b0;
            sa  <= 1'b0;
            sq  <= 1'b0;
            dz  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        acc <= '0;
                        qm1 <= 1'b0;
                        dz  <= dz0;
                        sa  <= src_a[WIDTH-1];
                        sq  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        mq  <= op_div ? abs_a : src_b;
                        opb <= op_div ? abs_b : src_a;
                    end
                end
                S_MULT: begin
                    acc <= booth_acc;
                    mq  <= booth_mq;
                    qm1 <= mq[0];
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= {1'b0, div_rem};
                    mq  <= div_q;
                    cnt <= cnt + 1'b1;
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_control.sv
// tb_muldiv_control: directed + randomized bench for muldiv_control.
// A cycle-level timeline model predicts busy/done/divby0/hi/lo.
module tb_muldiv_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, divby0;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_control #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_div(op_div), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .divby0(divby0),
        .hi(hi), .lo(lo)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic, latency as a count.
    function automatic void predict(
        input bit d, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] ohi, input logic [31:0] olo,
        output int lat, output logic [31:0] rh,
        output logic [31:0] rl, output bit z);
        longint la, lb, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        z = 1'b0; rh = ohi; rl = olo;
        if (!d) begin
            r = la * lb;
            rh = r[63:32]; rl = r[31:0];
            lat = 33;
`ifdef MULDIV_EARLY_ZERO_EN
            if (a == 0 || b == 0) lat = 1;
`endif
        end else if (b == 0) begin
            z = 1'b1; lat = 1;
        end else begin
            r = la / lb; rl = r[31:0];
            r = la % lb; rh = r[31:0];
            lat = 34;
`ifdef MULDIV_EARLY_ZERO_EN
            if (a == 0) lat = 1;
`endif
        end
    endfunction

    bit          m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_cnt = 0, m_lat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dz = 0;
            m_hi = '0; m_lo = '0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0; m_dz = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_dz = p_dz;
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            predict(op_div, src_a, src_b, m_hi, m_lo,
                    m_lat, p_hi, p_lo, p_dz);
            m_busy = 1;
            if (m_lat == 1) begin
                m_done = 1; m_dz = p_dz;
                m_hi = p_hi; m_lo = p_lo;
            end else begin
                m_cnt = m_lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("divby0", 32'(divby0), 32'(m_dz));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic issue(input bit d, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        #1;
        start = 1'b1; op_div = d; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_div = 1'($urandom_range(0, 1));
        src_a = 32'($urandom);
        src_b = 32'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit z);
        lat = -1; z = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i; z = divby0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL timeout got no done want done @%0t", $time);
    endtask

    task automatic run(input bit d, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output bit z);
        issue(d, a, b);
        wait_done(lat, z);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 31)) - 32'd16;
            default: return 32'($urandom);
        endcase
    endfunction

    int lat;
    bit z;
    int ndone;

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dz", 32'(divby0), 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        #1 rst_n = 1'b1;

        run(0, 32'd7, 32'hFFFF_FFFD, lat, z);
        chk("m7x-3_lat", lat, 33);
        chk("m7x-3_hi", hi, 32'hFFFF_FFFF);
        chk("m7x-3_lo", lo, 32'hFFFF_FFEB);

        run(1, 32'hFFFF_FFF9, 32'd2, lat, z);
        chk("d-7/2_lat", lat, 34);
        chk("d-7/2_lo", lo, 32'hFFFF_FFFD);
        chk("d-7/2_hi", hi, 32'hFFFF_FFFF);

        run(1, 32'h8000_0000, 32'hFFFF_FFFF, lat, z);
        chk("dmin_lo", lo, 32'h8000_0000);
        chk("dmin_hi", hi, 32'h0);
        chk("dmin_dz", 32'(z), 0);

        // Start pulse mid-multiply must be dropped.
        issue(0, 32'd1000, 32'hFFFF_FC18);
        repeat (10) @(negedge clk);
        #1;
        start = 1'b1; op_div = 1'b1; src_b = '0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, z);
        chk("ign_hi", hi, 32'hFFFF_FFFF);
        chk("ign_lo", lo, 32'hFFF0_BDC0);
        chk("ign_dz", 32'(z), 0);

        run(0, 32'd3, 32'd5, lat, z);
        chk("m3x5_lat", lat, 33);
        chk("m3x5_lo", lo, 32'd15);

        run(1, 32'd5, 32'd0, lat, z);
        chk("dz_lat", lat, 1);
        chk("dz_flag", 32'(z), 1);
        chk("dz_hi", hi, 0);
        chk("dz_lo", lo, 32'd15);

        // Reset in the middle of a divide.
        issue(1, 32'd1000, 32'd7);
        repeat (12) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_nodone", ndone, 0);

        run(1, 32'd100, 32'hFFFF_FFF9, lat, z);
        run(0, 32'd0, 32'h1234_5678, lat, z);
`ifdef MULDIV_EARLY_ZERO_EN
        chk("m0_lat", lat, 1);
`else
        chk("m0_lat", lat, 33);
`endif
        chk("m0_hi", hi, 0);
        chk("m0_lo", lo, 0);

        repeat (3000) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 7) == 0);
            op_div = 1'($urandom_range(0, 1));
            src_a = rv();
            src_b = rv();
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        #1 start = 1'b0; rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_control.md
# muldiv_control

Multi-cycle sequencer for the signed multiply/divide unit behind the HI/LO registers. The main control unit raises `start` with an operation code when it issues mult or div. This block then runs a Booth radix-2 multiply or a restoring divide over 32 iterations. On completion it writes HI/LO and returns a one-cycle `done`, with `divby0` flagging a zero divisor to the exception logic. The main control stalls on `busy`, and mfhi/mflo read `hi`/`lo` directly.

## Interface

Parameters
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits, and the iteration count equals `WIDTH`.

Ports
- `clk` in 1: the single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: operation request. Sampled only in IDLE.
- `op_div` in 1: 0 = signed multiply, 1 = signed divide. Sampled with `start`.
- `src_a` in WIDTH: multiplicand or dividend (rs).
- `src_b` in WIDTH: multiplier or divisor (rt).
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; HI/LO are valid in this cycle.
- `divby0` out 1: one-cycle pulse coincident with `done` when a divide had `src_b` = 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation

States: IDLE, MULT, DIV, FIX, DONE.

IDLE
- Takes `start` = 1 at rising edge T and latches operands. Iteration counter is cleared to 0.
- `op_div` = 0: go to MULT.
- `op_div` = 1 and `src_b` ≠ 0: go to DIV.
- `op_div` = 1 and `src_b` = 0: go straight to DONE. Assert `divby0`; HI/LO are unchanged.

MULT
- Booth radix-2 over a 2·WIDTH+1 product register {acc, multiplier, q-1}.
- Per edge: add, subtract or keep based on the bit pair, then arithmetic shift right by 1 and increment the counter.
- On the edge where the counter reaches WIDTH−1: {hi, lo} ← full 2·WIDTH signed product; go to DONE.

DIV
- Restoring divide on the magnitudes |a| and |b|, held as WIDTH-bit unsigned values.
- Per edge: shift remainder/quotient left, trial-subtract, restore if negative, set the quotient bit.
- After WIDTH iterations go to FIX.

FIX
- Apply signs in one edge, then go to DONE.
- lo ← quotient, negated if sign(a) ≠ sign(b). Quotient truncates toward zero.
- hi ← remainder, negated if a < 0. The remainder takes the dividend's sign.
- −2^(W−1) / −1 gives lo = 0x80000000, hi = 0, with no flag.

DONE
- `done` = 1 for exactly one cycle, then IDLE on the next edge.

Arithmetic: all internal sums are WIDTH+1 bits; no carry out of the product or quotient is lost.

Boundary conditions
- `start` while busy: ignored, not queued. A new `start` is accepted in IDLE on the edge directly after DONE.
- `op_div`, `src_a`, `src_b` changing mid-operation: no effect, since operands are latched at T.
- Reset, at any time including mid-operation: immediately state = IDLE and counter = 0, and all outputs go to their reset values.

Output reset values: `busy` 0, `done` 0, `divby0` 0, `hi` 0, `lo` 0.

## Timing

- `busy` is combinational from state and rises in the cycle after edge T.
- `done` and `divby0` are decoded from the state register, so they are glitch-free.
- Multiply: steps on edges T+1…T+32; HI/LO written at T+32; `done` high in the cycle after T+32. Latency is 33 cycles from `start` to `done`.
- Divide: steps on edges T+1…T+32; FIX at T+33; `done` high in the cycle after T+33. Latency is 34 cycles.
- Divide by zero: `done` and `divby0` are high in the cycle after T. Latency is 1 cycle.
- `hi` and `lo` change only on the edge that enters DONE, or on reset. They are stable at all other times, including while busy.

## Configuration

- `MULDIV_EARLY_ZERO_EN` defined:
  - Multiply with `src_a` = 0 or `src_b` = 0 goes IDLE→DONE at T with hi = lo = 0.
  - Divide with `src_a` = 0 and `src_b` ≠ 0 does the same.
  - Latency in both cases is 1 cycle, with `divby0` = 0.
  - A zero divisor still takes the `divby0` path, and that check has priority.
- Not defined: zero operands run the full 33/34-cycle sequence, with identical results.

## Test plan

- mult 7 × −3 (0x00000007, 0xFFFFFFFD): expect hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. `done` in the cycle after T+32, `busy` high for exactly 33 cycles.
- div −7 / 2: expect lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, `done` in the cycle after T+33. Then div 0x80000000 / 0xFFFFFFFF: expect lo = 0x80000000, hi = 0.
- Preload hi/lo with mult 3×5 (hi = 0, lo = 15), then div 5 / 0: expect `done` = `divby0` = 1 in the cycle after T, with hi = 0 and lo = 15 retained.
- Pulse `start` with `op_div` = 1 at iteration 10 of a mult: expect it ignored and the mult result correct. A `start` on the edge after DONE is accepted.
- Assert `rst_n` low at iteration 12 of a divide: expect `busy`, `done`, `hi`, `lo` = 0 immediately, with no `done` after release.
- mult 0 × 0x12345678: with `MULDIV_EARLY_ZERO_EN`, `done` in the cycle after T with hi = lo = 0; without it, `done` in the cycle after T+32 with the same result.
